// File: rtl/display_scan_multiplexer_pkg.sv
// Shared definitions for the display scan multiplexer: slot state encoding,
// a width helper and a parameter legality check.
package display_scan_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return (w == 0) ? 1 : w;
  endfunction

  // Legal when 2 <= channels <= 16 and prescale > blank >= 1.
  function automatic bit params_ok(input int unsigned channels,
                                   input int unsigned prescale,
                                   input int unsigned blank);
    return (channels >= 2) && (channels <= 16) && (blank >= 1) && (prescale > blank);
  endfunction

endpackage

// File: rtl/display_scan_multiplexer_if.sv
// Bus between the BCD registers / scan controller and the digit drivers.
//   scan_enable_in, manual_address_in, data_in, blank_mask_in : to scanner
//   mux_output, digit_select_out, address_out, frame_start_out : from scanner
interface display_scan_multiplexer_if import display_scan_pkg::*; #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 4
);
  localparam int unsigned ADDR_WIDTH = clog2_min1(CHANNELS);

  logic                           scan_enable_in;
  logic [ADDR_WIDTH-1:0]          manual_address_in;
  logic [CHANNELS*DATA_WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]            blank_mask_in;
  logic [DATA_WIDTH-1:0]          mux_output;
  logic [CHANNELS-1:0]            digit_select_out;
  logic [ADDR_WIDTH-1:0]          address_out;
  logic                           frame_start_out;

  modport master (
    output scan_enable_in, manual_address_in, data_in, blank_mask_in,
    input  mux_output, digit_select_out, address_out, frame_start_out
  );

  modport slave (
    input  scan_enable_in, manual_address_in, data_in, blank_mask_in,
    output mux_output, digit_select_out, address_out, frame_start_out
  );
endinterface

// File: rtl/display_scan_multiplexer_scan_slot_timer.sv
// Slot timer: BLANK for BLANK_CYCLES cycles, then SHOW until PRESCALE cycles.
//   clk_in, reset_n_in : clock, synchronous active-low reset
//   in_show_c          : the cycle after this edge is a SHOW cycle
//   slot_end_c         : this edge ends the current slot
//   show_first_c       : the cycle after this edge is the first SHOW cycle
module scan_slot_timer import display_scan_pkg::*; #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clk_in,
  input  logic reset_n_in,
  output logic in_show_c,
  output logic slot_end_c,
  output logic show_first_c
);
  localparam int unsigned CNT_W = clog2_min1(PRESCALE);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Decisions look one cycle ahead so the top can register outputs in step.
  assign show_first_c = (state == ST_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end_c   = (state == ST_SHOW)  && (cnt == CNT_W'(PRESCALE - 1));
  assign in_show_c    = show_first_c || ((state == ST_SHOW) && !slot_end_c);

  // Slot counter and state register.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state <= ST_BLANK;
      cnt   <= '0;
    end else if (slot_end_c) begin
      state <= ST_BLANK;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (show_first_c) state <= ST_SHOW;
    end
  end
endmodule

// File: rtl/display_scan_multiplexer.sv
// Time-multiplexed digit scanner with per-slot blanking, auto/manual address
// modes and per-channel leading-zero masking.
//   clk_in, reset_n_in : clock, synchronous active-low reset
//   bus (slave)        : mode/address/data/mask in; digit code, one-hot
//                        enable, slot address and frame pulse out (registered)
module display_scan_multiplexer import display_scan_pkg::*; #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                        clk_in,
  input  logic                        reset_n_in,
  display_scan_multiplexer_if.slave   bus
);
  localparam int unsigned ADDR_WIDTH = clog2_min1(CHANNELS);

  if (!params_ok(CHANNELS, PRESCALE, BLANK_CYCLES)) begin : g_param_check
    $error("display_scan_multiplexer: illegal CHANNELS/PRESCALE/BLANK_CYCLES");
  end

  logic                  in_show_c;
  logic                  slot_end_c;
  logic                  show_first_c;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_inc_c;
  logic [CHANNELS-1:0]   sel_c;
  logic [DATA_WIDTH-1:0] digit_c;

  scan_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .in_show_c    (in_show_c),
    .slot_end_c   (slot_end_c),
    .show_first_c (show_first_c)
  );

  // Next auto address; out-of-range addresses also fold back to 0.
  assign addr_inc_c = (addr_q >= ADDR_WIDTH'(CHANNELS - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

  // Channel select; masked or out-of-range addresses yield all zeros.
  always_comb begin
    sel_c   = '0;
    digit_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((addr_q == ADDR_WIDTH'(i)) && !bus.blank_mask_in[i]) begin
        sel_c[i] = 1'b1;
        digit_c  = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Address/mode update at slot boundaries and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      addr_q               <= '0;
      mode_q               <= bus.scan_enable_in;
      bus.mux_output       <= '0;
      bus.digit_select_out <= '0;
      bus.frame_start_out  <= 1'b0;
    end else begin
      if (slot_end_c) begin
        addr_q <= bus.scan_enable_in ? addr_inc_c : bus.manual_address_in;
        mode_q <= bus.scan_enable_in;
      end
      bus.digit_select_out <= in_show_c ? sel_c   : '0;
      bus.mux_output       <= in_show_c ? digit_c : '0;
      bus.frame_start_out  <= show_first_c && mode_q && (addr_q == '0);
    end
  end

  assign bus.address_out = addr_q;
endmodule

// File: tb/tb_display_scan_multiplexer.sv
// Self-checking bench for display_scan_multiplexer (4- and 6-channel instances).
module tb_display_scan_multiplexer;
  import display_scan_pkg::*;

  localparam int P = 8;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_multiplexer_if #(.CHANNELS(4), .DATA_WIDTH(4)) bus4 ();
  display_scan_multiplexer_if #(.CHANNELS(6), .DATA_WIDTH(4)) bus6 ();

  display_scan_multiplexer #(.CHANNELS(4), .DATA_WIDTH(4), .PRESCALE(P), .BLANK_CYCLES(B))
    dut4 (.clk_in(clk), .reset_n_in(rst_n), .bus(bus4));
  display_scan_multiplexer #(.CHANNELS(6), .DATA_WIDTH(4), .PRESCALE(P), .BLANK_CYCLES(B))
    dut6 (.clk_in(clk), .reset_n_in(rst_n), .bus(bus6));

  int total = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model: slot phase = cycles since slot start, address per slot.
  int m_phase[2];
  int m_addr[2];
  int m_mode[2];
  int e_sel[2];
  int e_mux[2];
  int e_frame[2];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] sel;
    logic [3:0] mux;
    logic       frame;
  } slot_vec_t;
  slot_vec_t tbl[9];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s cycle=%0d got=timeout expected=event", name, cyc);
  endtask

  task automatic adv(input int d, input logic rst, input logic scan, input int man,
                     input logic [95:0] data, input logic [15:0] mask, input int ch);
    if (!rst) begin
      m_phase[d] = 0; m_addr[d] = 0; m_mode[d] = int'(scan);
      e_sel[d] = 0; e_mux[d] = 0; e_frame[d] = 0;
    end else begin
      m_phase[d] = (m_phase[d] + 1) % P;
      if (m_phase[d] == 0) begin
        m_addr[d] = scan ? (m_addr[d] + 1) % ch : man;
        m_mode[d] = int'(scan);
      end
      e_sel[d] = 0; e_mux[d] = 0; e_frame[d] = 0;
      if (m_phase[d] >= B) begin
        if (m_addr[d] < ch && !mask[m_addr[d]]) begin
          e_sel[d] = 1 << m_addr[d];
          e_mux[d] = int'((data >> (m_addr[d] * 4)) & 96'hF);
        end
        e_frame[d] = (m_phase[d] == B && m_addr[d] == 0 && m_mode[d] != 0) ? 1 : 0;
      end
    end
  endtask

  // One clock: model consumes pre-edge inputs, DUT outputs checked #1 after edge.
  task automatic tick();
    adv(0, rst_n, bus4.scan_enable_in, int'(bus4.manual_address_in),
        96'(bus4.data_in), 16'(bus4.blank_mask_in), 4);
    adv(1, rst_n, bus6.scan_enable_in, int'(bus6.manual_address_in),
        96'(bus6.data_in), 16'(bus6.blank_mask_in), 6);
    @(posedge clk);
    #1;
    cyc++;
    chk("sel4",   int'(bus4.digit_select_out), e_sel[0]);
    chk("mux4",   int'(bus4.mux_output),       e_mux[0]);
    chk("frame4", int'(bus4.frame_start_out),  e_frame[0]);
    chk("addr4",  int'(bus4.address_out),      m_addr[0]);
    chk("onehot4", ($countones(bus4.digit_select_out) <= 1) ? 1 : 0, 1);
    chk("sel6",   int'(bus6.digit_select_out), e_sel[1]);
    chk("mux6",   int'(bus6.mux_output),       e_mux[1]);
    chk("frame6", int'(bus6.frame_start_out),  e_frame[1]);
    chk("addr6",  int'(bus6.address_out),      m_addr[1]);
  endtask

  task automatic wait_slot(input int d, input int addr, input int phase, input string name);
    int n;
    n = 0;
    while (!(m_addr[d] == addr && m_phase[d] == phase) && n < 80) begin
      tick();
      n++;
    end
    if (!(m_addr[d] == addr && m_phase[d] == phase)) timeout(name);
  endtask

  initial begin
    tbl[0] = '{4'b0000, 4'b0001, 4'h3, 1'b1};
    tbl[1] = '{4'b0000, 4'b0010, 4'h5, 1'b0};
    tbl[2] = '{4'b0000, 4'b0100, 4'h9, 1'b0};
    tbl[3] = '{4'b0000, 4'b1000, 4'h1, 1'b0};
    tbl[4] = '{4'b0000, 4'b0001, 4'h3, 1'b1};
    tbl[5] = '{4'b1000, 4'b0010, 4'h5, 1'b0};
    tbl[6] = '{4'b1000, 4'b0100, 4'h9, 1'b0};
    tbl[7] = '{4'b1000, 4'b0000, 4'h0, 1'b0};
    tbl[8] = '{4'b1000, 4'b0001, 4'h3, 1'b1};

    bus4.scan_enable_in = 1'b1; bus4.manual_address_in = '0;
    bus4.data_in = 16'h1953;    bus4.blank_mask_in = '0;
    bus6.scan_enable_in = 1'b0; bus6.manual_address_in = 3'd7;
    bus6.data_in = 24'h654321;  bus6.blank_mask_in = '0;

    // Reset held for five cycles.
    rst_n = 1'b0;
    repeat (5) tick();
    chk("rst_sel", int'(bus4.digit_select_out), 0);
    chk("rst_mux", int'(bus4.mux_output), 0);
    chk("rst_addr", int'(bus4.address_out), 0);
    chk("rst_frame", int'(bus4.frame_start_out), 0);
    rst_n = 1'b1;

    // Table: auto scan, wrap, then channel 3 masked.
    for (int k = 0; k < 9; k++) begin
      bus4.blank_mask_in = tbl[k].mask;
      for (int c = 0; c < P; c++) begin
        int ph;
        tick();
        ph = (c + 1) % P;
        chk("tbl_sel", int'(bus4.digit_select_out), (ph >= B) ? int'(tbl[k].sel) : 0);
        chk("tbl_mux", int'(bus4.mux_output), (ph >= B) ? int'(tbl[k].mux) : 0);
        chk("tbl_frame", int'(bus4.frame_start_out), (ph == B) ? int'(tbl[k].frame) : 0);
      end
    end
    bus4.blank_mask_in = '0;

    // Data change during SHOW of slot 1 appears one cycle later.
    wait_slot(0, 1, 4, "wait_data");
    bus4.data_in = 16'h19A3;
    tick();
    chk("data_mux", int'(bus4.mux_output), 'hA);
    chk("data_sel", int'(bus4.digit_select_out), 'b0010);

    // Manual mode requested mid-slot 0: slot 0 completes, then address 2 holds.
    wait_slot(0, 0, 3, "wait_manual");
    bus4.scan_enable_in = 1'b0;
    bus4.manual_address_in = 2'd2;
    for (int c = 4; c < P; c++) begin
      tick();
      chk("man_tail_sel", int'(bus4.digit_select_out), 'b0001);
    end
    for (int c = 0; c < 2 * P; c++) begin
      tick();
      chk("man_sel", int'(bus4.digit_select_out), (m_phase[0] >= B) ? 'b0100 : 0);
      chk("man_mux", int'(bus4.mux_output), (m_phase[0] >= B) ? 'h9 : 0);
      chk("man_frame", int'(bus4.frame_start_out), 0);
    end

    // Reset in the third SHOW cycle of slot 2.
    bus4.scan_enable_in = 1'b1;
    wait_slot(0, 2, 3, "wait_reset");
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sel", int'(bus4.digit_select_out), 0);
    chk("mid_rst_mux", int'(bus4.mux_output), 0);
    chk("mid_rst_addr", int'(bus4.address_out), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_blank", int'(bus4.digit_select_out), 0);
    tick();
    chk("restart_sel", int'(bus4.digit_select_out), 'b0001);
    chk("restart_mux", int'(bus4.mux_output), 'h3);
    chk("restart_frame", int'(bus4.frame_start_out), 1);

    // Six-channel instance parked on out-of-range address 7.
    wait_slot(1, 7, 3, "wait_oor");
    chk("oor_sel", int'(bus6.digit_select_out), 0);
    chk("oor_mux", int'(bus6.mux_output), 0);
    chk("oor_addr", int'(bus6.address_out), 7);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick();
      bus4.data_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus4.blank_mask_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus4.scan_enable_in = ~bus4.scan_enable_in;
      if ($urandom_range(0, 9) == 0) bus4.manual_address_in = 2'($urandom);
      if ($urandom_range(0, 5) == 0) bus6.data_in = 24'($urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
